// File: rtl/pc_flow_unit.sv
// rtl/pc_flow_unit.sv - program counter and branch/jump flow resolution stage
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   stall               hold all state; suppress link write and error capture
//   branch, brnv, bgtzal, balv, jmnor, jrsal
//                       flow strobes from the main control decoder
//   flag_we             latch {alu_neg, alu_ovf, alu_zero} into flags
//   alu_zero/neg/ovf    current ALU status
//   imm16               branch offset in words
//   rs_val              rs read data (jrsal target, bgtzal operand)
//   mem_rdata           jmnor target
//   pc, pc_plus4        current PC (registered) and pc + 4
//   link_we/reg/data    $31 link write for linking forms
//   flags               registered {N,V,Z}
//   multi_err           sticky: more than one flow strobe in a cycle
//   misalign_err        sticky: taken target had nonzero low bits
//   retired_cnt         non-stall cycles, wraps
//   taken_cnt           taken redirects, wraps
module pc_flow_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  LINK_REG = 5'd31,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch,
  input  logic             brnv,
  input  logic             bgtzal,
  input  logic             balv,
  input  logic             jmnor,
  input  logic             jrsal,
  input  logic             flag_we,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  input  logic [15:0]      imm16,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             link_we,
  output logic [4:0]       link_reg,
  output logic [31:0]      link_data,
  output logic [2:0]       flags,
  output logic             multi_err,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q, pc_d;
  logic [2:0]       flags_q, flags_d;
  logic             multi_q, multi_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] taken_q, taken_d;

  logic [5:0]  strobes;
  logic        any_strobe;
  logic        multi_strobe;
  logic        single_strobe;
  logic [31:0] btarget;
  logic [31:0] target;
  logic        cond_taken;
  logic        redirect;
  logic        rs_gt_zero;
  logic        flag_v;

  assign pc_plus4 = pc_q + 32'd4;
  assign btarget  = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign strobes       = {branch, brnv, bgtzal, balv, jmnor, jrsal};
  assign any_strobe    = |strobes;
  assign multi_strobe  = |(strobes & (strobes - 6'd1));
  assign single_strobe = any_strobe & ~multi_strobe;

  assign rs_gt_zero = ~rs_val[31] & (|rs_val[30:0]);
  assign flag_v     = flags_q[1];

  // Only meaningful when exactly one strobe is high; brnv/balv test the
  // registered V so a same-cycle flag_we does not affect them.
  always_comb begin
    target     = btarget;
    cond_taken = 1'b0;
    if (branch) begin
      cond_taken = alu_zero;
    end else if (brnv) begin
      cond_taken = ~flag_v;
    end else if (balv) begin
      cond_taken = flag_v;
    end else if (bgtzal) begin
      cond_taken = rs_gt_zero;
    end else if (jmnor) begin
      cond_taken = 1'b1;
      target     = mem_rdata;
    end else if (jrsal) begin
      cond_taken = 1'b1;
      target     = rs_val;
    end
  end

  assign redirect = single_strobe & cond_taken;

  // rst_n gating keeps the register file from being written while in reset.
  assign link_we   = rst_n & ~stall & single_strobe &
                     (jrsal | ((bgtzal | balv) & cond_taken));
  assign link_reg  = LINK_REG;
  assign link_data = pc_plus4;

  always_comb begin
    pc_d       = pc_q;
    flags_d    = flags_q;
    multi_d    = multi_q;
    misalign_d = misalign_q;
    retired_d  = retired_q;
    taken_d    = taken_q;
    if (!stall) begin
      pc_d      = redirect ? {target[31:2], 2'b00} : pc_plus4;
      retired_d = retired_q + CNT_ONE;
      if (redirect) begin
        taken_d = taken_q + CNT_ONE;
        if (target[1:0] != 2'b00) begin
          misalign_d = 1'b1;
        end
      end
      if (multi_strobe) begin
        multi_d = 1'b1;
      end
      if (flag_we) begin
        flags_d = {alu_neg, alu_ovf, alu_zero};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      flags_q    <= 3'b000;
      multi_q    <= 1'b0;
      misalign_q <= 1'b0;
      retired_q  <= '0;
      taken_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      flags_q    <= flags_d;
      multi_q    <= multi_d;
      misalign_q <= misalign_d;
      retired_q  <= retired_d;
      taken_q    <= taken_d;
    end
  end

  assign pc           = pc_q;
  assign flags        = flags_q;
  assign multi_err    = multi_q;
  assign misalign_err = misalign_q;
  assign retired_cnt  = retired_q;
  assign taken_cnt    = taken_q;

endmodule
